// File: rtl/pwm_duty_meter.sv
// PWM input meter: measures period and high time of iPWM and converts them to an 8-bit duty
// code (floor(high*256/period), saturating at 255) with a 9-step restoring divider.
module pwm_duty_meter #(
  parameter int unsigned TPWM_MAX = 4095,
  localparam int unsigned NCNT = $clog2(TPWM_MAX + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iPWM,
  output logic [7:0]      duty,
  output logic [NCNT-1:0] period,
  output logic            valid,
  output logic            stuck,
  output logic            locked
);

  localparam int unsigned MIN_PERIOD = 16;
  localparam int unsigned PW = NCNT + 1;  // snapshot width: P can reach TPWM_MAX+1
  localparam int unsigned RW = PW + 1;    // remainder width: holds up to 2*P

  localparam logic [NCNT-1:0] CntMax = NCNT'(TPWM_MAX);
  localparam logic [PW-1:0]   PMax   = PW'(TPWM_MAX);
  localparam logic [PW-1:0]   PMin   = PW'(MIN_PERIOD);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_RUN  = 2'd1;
  localparam logic [1:0] D_DONE = 2'd2;

  logic            s1_q, s2_q, s3_q;
  logic [NCNT-1:0] pcnt_q, pcnt_d;
  logic [NCNT-1:0] hcnt_q, hcnt_d;
  logic            armed_q, armed_d;
  logic [1:0]      state_q, state_d;
  logic [3:0]      iter_q, iter_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [8:0]      quo_q, quo_d;
  logic [PW-1:0]   div_q, div_d;
  logic [7:0]      duty_q, duty_d;
  logic [NCNT-1:0] period_q, period_d;
  logic            valid_q, valid_d;
  logic            stuck_q, stuck_d;
  logic            locked_q, locked_d;

  logic          rise, busy, timeout, result_load, trial_ge;
  logic [PW-1:0] p_snap, h_snap;
  logic [RW-1:0] div_ext, rem_sub;
  logic [8:0]    quo_step;

  assign rise   = s2_q & ~s3_q;
  assign p_snap = {1'b0, pcnt_q} + {{NCNT{1'b0}}, 1'b1};
  assign h_snap = {1'b0, hcnt_q} + {{NCNT{1'b0}}, s2_q};
  assign busy   = (state_q != D_IDLE);

  // One restoring step: compare, conditionally subtract, shift the remainder for the next bit.
  assign div_ext     = {1'b0, div_q};
  assign trial_ge    = (rem_q >= div_ext);
  assign rem_sub     = trial_ge ? (rem_q - div_ext) : rem_q;
  assign quo_step    = (quo_q << 1) | {8'b0, trial_ge};
  assign result_load = (state_q == D_RUN) && (iter_q == 4'd8);

  // Only an armed meter can time out; once disarmed it waits silently for fresh edges.
  assign timeout = armed_q && (pcnt_q == CntMax) && !rise;

  always_comb begin
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    armed_d  = armed_q;
    state_d  = state_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    locked_d = locked_q;

    if (rise) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else begin
      if (pcnt_q != CntMax) pcnt_d = pcnt_q + 1'b1;
      if (s2_q && (hcnt_q != CntMax)) hcnt_d = hcnt_q + 1'b1;
    end

    case (state_q)
      D_RUN: begin
        quo_d  = quo_step;
        rem_d  = rem_sub << 1;
        iter_d = iter_q + 4'd1;
        if (result_load) begin
          state_d  = D_DONE;
          duty_d   = quo_step[8] ? 8'hFF : quo_step[7:0];
          period_d = (div_q > PMax) ? CntMax : div_q[NCNT-1:0];
          stuck_d  = 1'b0;
          locked_d = 1'b1;
          valid_d  = 1'b1;
        end
      end
      D_DONE:  state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase

    if (rise) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (busy || (p_snap < PMin)) begin
        locked_d = 1'b0;
      end else begin
        state_d = D_RUN;
        iter_d  = 4'd0;
        quo_d   = '0;
        rem_d   = {1'b0, h_snap};
        div_d   = p_snap;
      end
    end else if (timeout && !result_load) begin
      duty_d   = s2_q ? 8'hFF : 8'h00;
      period_d = '0;
      stuck_d  = 1'b1;
      locked_d = 1'b0;
      valid_d  = 1'b1;
      armed_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      armed_q  <= 1'b0;
      state_q  <= D_IDLE;
      iter_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      s1_q     <= iPWM;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      locked_q <= locked_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: a background PWM generator drives iPWM while one linear
// sequence waits for valid pulses and compares outputs against hand-computed values.
module tb_pwm_duty_meter;

  localparam int unsigned TPWM_MAX = 4095;
  localparam int unsigned NCNT = $clog2(TPWM_MAX + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            iPWM = 1'b0;
  logic [7:0]      duty;
  logic [NCNT-1:0] period;
  logic            valid;
  logic            stuck;
  logic            locked;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int vb = 0;

  // Generator parameters are latched at each period boundary so changes never cut a period.
  int gen_per = 10;
  int gen_high = 0;
  bit gen_en = 1'b0;
  bit gen_level = 1'b0;
  int cur_per = 10;
  int cur_high = 0;
  int gen_ph = 0;
  bit cur_en = 1'b0;

  int hi_tab[3] = '{500, 1999, 1};
  int du_tab[3] = '{64, 255, 0};

  pwm_duty_meter #(.TPWM_MAX(TPWM_MAX)) dut (
    .clock  (clock),
    .reset  (reset),
    .iPWM   (iPWM),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck),
    .locked (locked)
  );

  initial forever #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (gen_ph == 0) begin
        cur_en   = gen_en;
        cur_per  = gen_per;
        cur_high = gen_high;
      end
      iPWM   = cur_en ? (gen_ph < cur_high) : gen_level;
      gen_ph = (gen_ph + 1 >= cur_per) ? 0 : gen_ph + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      if (valid === 1'b1) vcnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (valid !== 1'b1 && n < budget);
    check(tag, {31'b0, valid}, 32'd1);
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    check("rst_duty", {24'b0, duty}, 32'd0);
    check("rst_period", {20'b0, period}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_stuck", {31'b0, stuck}, 32'd0);
    check("rst_locked", {31'b0, locked}, 32'd0);
    reset = 1'b0;
    vb = vcnt;

    // 2000/1000: first rise only arms, the next two each report 128.
    gen_per = 2000;
    gen_high = 1000;
    gen_en = 1'b1;
    wait_valid(4300, "t1_valid1");
    check("t1_duty", {24'b0, duty}, 32'd128);
    check("t1_period", {20'b0, period}, 32'd2000);
    check("t1_locked", {31'b0, locked}, 32'd1);
    check("t1_stuck", {31'b0, stuck}, 32'd0);
    wait_valid(2100, "t1_valid2");
    @(negedge clock);
    check("t1_valid_count", vcnt - vb, 32'd2);
    check("t1_duty2", {24'b0, duty}, 32'd128);

    // Each new high time shows up on the second valid after it is requested.
    for (int i = 0; i < 3; i++) begin
      gen_high = hi_tab[i];
      wait_valid(2100, "t2_valid_a");
      wait_valid(2100, "t2_valid_b");
      check("t2_duty", {24'b0, duty}, du_tab[i]);
      check("t2_period", {20'b0, period}, 32'd2000);
      check("t2_locked", {31'b0, locked}, 32'd1);
    end

    // Line stuck high: final sample, then exactly one timeout report.
    gen_level = 1'b1;
    gen_en = 1'b0;
    wait_valid(2100, "t3_last_sample");
    check("t3_last_duty", {24'b0, duty}, 32'd0);
    @(negedge clock);
    vb = vcnt;
    wait_valid(4500, "t3_hi_timeout");
    check("t3_hi_duty", {24'b0, duty}, 32'd255);
    check("t3_hi_period", {20'b0, period}, 32'd0);
    check("t3_hi_stuck", {31'b0, stuck}, 32'd1);
    check("t3_hi_locked", {31'b0, locked}, 32'd0);
    repeat (1000) @(negedge clock);
    check("t3_hi_one_valid", vcnt - vb, 32'd1);

    gen_per = 2000;
    gen_high = 1000;
    gen_en = 1'b1;
    wait_valid(8000, "t3_relock");
    check("t3_relock_duty", {24'b0, duty}, 32'd128);
    check("t3_relock_stuck", {31'b0, stuck}, 32'd0);
    check("t3_relock_locked", {31'b0, locked}, 32'd1);

    // Line stuck low.
    gen_level = 1'b0;
    gen_en = 1'b0;
    wait_valid(4500, "t3_lo_timeout");
    check("t3_lo_duty", {24'b0, duty}, 32'd0);
    check("t3_lo_period", {20'b0, period}, 32'd0);
    check("t3_lo_stuck", {31'b0, stuck}, 32'd1);
    check("t3_lo_locked", {31'b0, locked}, 32'd0);

    // Restart at 400/100: first rise arms, second reports 64.
    @(negedge clock);
    vb = vcnt;
    gen_per = 400;
    gen_high = 100;
    gen_en = 1'b1;
    wait_valid(3000, "t3_restart");
    check("t3_restart_duty", {24'b0, duty}, 32'd64);
    check("t3_restart_period", {20'b0, period}, 32'd400);
    check("t3_restart_stuck", {31'b0, stuck}, 32'd0);
    check("t3_restart_locked", {31'b0, locked}, 32'd1);
    @(negedge clock);
    check("t3_restart_count", vcnt - vb, 32'd1);

    // Period 10 is below the minimum: samples dropped, outputs hold.
    gen_per = 10;
    gen_high = 5;
    wait_valid(600, "t4_last_400");
    check("t4_last_duty", {24'b0, duty}, 32'd64);
    @(negedge clock);
    vb = vcnt;
    repeat (300) @(negedge clock);
    check("t4_no_valid", vcnt - vb, 32'd0);
    check("t4_locked", {31'b0, locked}, 32'd0);
    check("t4_duty_hold", {24'b0, duty}, 32'd64);
    check("t4_period_hold", {20'b0, period}, 32'd400);
    check("t4_stuck", {31'b0, stuck}, 32'd0);

    // Latency: iPWM goes high after posedge 1, s1 samples it at posedge 2; counting that edge
    // as the first, valid rises on the 12th edge and is seen at negedge 13.
    gen_level = 1'b0;
    gen_en = 1'b0;
    repeat (60) @(negedge clock);
    gen_level = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      check("t5_latency", {31'b0, valid}, (k == 13) ? 32'd1 : 32'd0);
    end
    check("t5_locked", {31'b0, locked}, 32'd1);
    check("t5_stuck", {31'b0, stuck}, 32'd0);

    // Reset five edges into a divide.
    gen_level = 1'b0;
    repeat (30) @(negedge clock);
    gen_level = 1'b1;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    gen_level = 1'b0;
    @(negedge clock);
    check("t6_duty", {24'b0, duty}, 32'd0);
    check("t6_period", {20'b0, period}, 32'd0);
    check("t6_valid", {31'b0, valid}, 32'd0);
    check("t6_stuck", {31'b0, stuck}, 32'd0);
    check("t6_locked", {31'b0, locked}, 32'd0);
    vb = vcnt;
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("t6_aborted", vcnt - vb, 32'd0);
    gen_per = 1000;
    gen_high = 250;
    gen_en = 1'b1;
    wait_valid(2500, "t6_rearm");
    check("t6_rearm_duty", {24'b0, duty}, 32'd64);
    check("t6_rearm_period", {20'b0, period}, 32'd1000);
    check("t6_rearm_locked", {31'b0, locked}, 32'd1);
    @(negedge clock);
    check("t6_rearm_count", vcnt - vb, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
